// File: rtl/aer_frame_decoder.sv
// Decoder for 4-phase return-to-zero AER token frames (Fs, address, X0, direction, Fe).
// Synchronises the raw tokens, acknowledges them one at a time and pulses a per-channel up/down event per valid frame.
module aer_frame_decoder #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Fs,
  input  logic              X0,
  input  logic              Zero,
  input  logic              One,
  input  logic              Fe,
  output logic              Fs_ack,
  output logic              X0_ack,
  output logic              Zero_ack,
  output logic              One_ack,
  output logic              Fe_ack,
  output logic [NUM_CH-1:0] ch_up,
  output logic [NUM_CH-1:0] ch_down,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [2:0]        state_dbg
);

  localparam int BCW = $clog2(ADDR_W + 1);
  localparam int T_FS = 0, T_X0 = 1, T_ZERO = 2, T_ONE = 3, T_FE = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SEP   = 3'd2,
    DIR   = 3'd3,
    END   = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          sync_q [SYNC_STAGES];
  logic [4:0]          ack_q, ack_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic                dir_q, dir_d;
  logic [NUM_CH-1:0]   up_q, up_d, down_q, down_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4:0]          raw, tok;
  logic                tok_single, tok_multi, tok_bit;

  assign raw = {Fe, One, Zero, X0, Fs};
  assign tok = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign tok_multi  = (tok & (tok - 5'd1)) != 5'd0;
  assign tok_single = (tok != 5'd0) && !tok_multi;
  assign tok_bit    = tok[T_ZERO] | tok[T_ONE];

  // Handshake: a token is taken only when exactly one synchronised token is high and
  // every ack is low; its ack then holds until all synchronised tokens are low again.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    dir_d   = dir_q;
    up_d    = '0;
    down_d  = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (ack_q != 5'd0) begin
      if (tok == 5'd0) ack_d = '0;
    end else if (tok_multi) begin
      err_d   = 1'b1;
      state_d = DRAIN;
    end else if (tok_single) begin
      ack_d = tok;
      if (tok[T_FS]) begin
        // A restart from DRAIN is silent; the error was already reported on entry.
        err_d   = (state_q != IDLE) && (state_q != DRAIN);
        state_d = ADDR;
        addr_d  = '0;
        bcnt_d  = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
          ADDR: begin
            if (tok_bit) begin
              addr_d = ADDR_W'({addr_q, tok[T_ONE]});
              bcnt_d = bcnt_q + BCW'(1);
              if (bcnt_q == BCW'(ADDR_W - 1)) state_d = SEP;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
          SEP: begin
            if (tok[T_X0]) state_d = DIR;
            else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
          DIR: begin
            if (tok_bit) begin
              dir_d   = tok[T_ONE];
              state_d = END;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
          END: begin
            if (tok[T_FE]) begin
              state_d = IDLE;
              if (int'(addr_q) < NUM_CH) begin
                if (dir_q) up_d = NUM_CH'(1) << addr_q;
                else       down_d = NUM_CH'(1) << addr_q;
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                err_d = 1'b1;
              end
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
          DRAIN: begin
            if (tok[T_FE]) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      dir_q   <= 1'b0;
      up_q    <= '0;
      down_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      down_q  <= down_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Fs_ack    = ack_q[T_FS];
  assign X0_ack    = ack_q[T_X0];
  assign Zero_ack  = ack_q[T_ZERO];
  assign One_ack   = ack_q[T_ONE];
  assign Fe_ack    = ack_q[T_FE];
  assign ch_up     = up_q;
  assign ch_down   = down_q;
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: doc/aer_frame_decoder.md
AER_FRAME_DECODER -- requirements
Module: aer_frame_decoder

Interface
REQ-001 Parameter NUM_CH, default 2: number of output channels, minimum 1.
REQ-002 Parameter ADDR_W, default 1: address bits per frame; 2**ADDR_W >= NUM_CH SHALL hold.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on token inputs, minimum 2.
REQ-004 Parameter CNT_W, default 16: width of the valid-frame counter.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 Fs, X0, Zero, One, Fe  input  1 each  asynchronous return-to-zero tokens: frame start, separator, data 0, data 1, frame end.
REQ-008 Fs_ack, X0_ack, Zero_ack, One_ack, Fe_ack  output  1 each  registered 4-phase acknowledges.
REQ-009 ch_up, ch_down  output  NUM_CH each  one-cycle event pulses, one bit per channel.
REQ-010 frame_err  output  1  one-cycle protocol-error pulse.
REQ-011 frame_cnt  output  CNT_W  count of valid frames.

Function
REQ-012 Each token input SHALL pass through SYNC_STAGES flops before use; all decisions use synchronised values only.
REQ-013 A token is accepted when exactly one synchronised token is high and all acks are low; its ack rises on the next edge.
REQ-014 An ack stays high until all synchronised tokens are low, then falls on the next edge; no new token is accepted while any ack is high.
REQ-015 Two or more synchronised tokens high with all acks low: no ack, frame_err pulse, state -> DRAIN; then evaluate again each cycle.
REQ-016 Frame format: Fs, ADDR_W address bits MSB first (Zero/One), X0, one direction bit (One = up, Zero = down), Fe.
REQ-017 States: IDLE, ADDR, SEP, DIR, END, DRAIN.
REQ-018 IDLE: Fs -> ADDR, address shift register cleared, bit count 0.
REQ-019 ADDR: Zero/One shifts the bit in; after the ADDR_W-th bit -> SEP.
REQ-020 SEP: X0 -> DIR.
REQ-021 DIR: Zero/One latches direction -> END.
REQ-022 END: Fe -> IDLE; if address < NUM_CH, pulse ch_up[addr] or ch_down[addr] and increment frame_cnt in the same cycle Fe_ack rises.
REQ-023 END with address >= NUM_CH: Fe acked, frame_err pulses, no channel pulse, no count, -> IDLE.
REQ-024 Fs in any state other than IDLE: accept and ack; frame_err pulses; restart as in REQ-018.
REQ-025 Any other token illegal for the current state: ack it, frame_err pulses, -> DRAIN.
REQ-026 DRAIN: ack every token with no other effect; Fe -> IDLE; Fs restarts as in REQ-018 without a second error.
REQ-027 frame_cnt wraps from 2**CNT_W-1 to 0 with no flag.
REQ-028 At most one ch_up/ch_down bit is high in any cycle; pulses last exactly one cycle.
REQ-029 Latency: raw token edge to ack edge is SYNC_STAGES+1 cycles.

Reset
REQ-030 With reset low: state IDLE; sync flops, acks, ch_up, ch_down, frame_err, frame_cnt, address and direction all 0; takes effect immediately, with no clock edge needed.
REQ-031 Reset released mid-frame SHALL restart in IDLE with no pulse; tokens still high after release are handled per REQ-025, with IDLE treating non-Fs tokens as illegal.

Verification (NUM_CH=3, ADDR_W=2, SYNC_STAGES=2, CNT_W=4)
V-1 Fs,One,Zero,X0,One,Fe, full 4-phase handshake -> ch_up=3'b100 for one cycle with Fe_ack rise; frame_cnt=1.
V-2 Fs,Zero,One,X0,Zero,Fe -> ch_down=3'b010 pulse; frame_cnt increments.
V-3 Frame with address 2'b11 -> frame_err pulse at Fe, no channel pulse, frame_cnt unchanged.
V-4 Fs,Zero,Fe (premature Fe) -> frame_err pulse at Fe acceptance, DRAIN, next Fe -> IDLE; a following valid frame decodes correctly.
V-5 Zero and One raised together in ADDR -> no ack, frame_err, DRAIN; check raw-to-ack latency of 3 cycles on a single token.
V-6 16 valid frames -> frame_cnt wraps to 0; reset asserted mid-ADDR -> all outputs 0 asynchronously, next frame decodes normally.
